wb_slave_ram: RTL and testbench
===============================

# wb_slave_ram

Wishbone classic-cycle responder wrapping a word-organised on-chip RAM, the slave-side counterpart to the CPU's Wishbone initiator. It decodes a single address window, inserts a fixed number of wait states, performs byte-masked writes or registered reads, and answers each accepted cycle with exactly one `wb_ack_o` pulse. Out-of-window accesses get a single `wb_err_o` pulse instead. It sits on the system bus next to the CPU's instruction and data initiators.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; capacity 2^ADDR_WIDTH words of `RegWidth` (32) bits.
- `BASE_ADDR`, 32'h0000_0000: window base; must be aligned to 4·2^ADDR_WIDTH bytes.
- `WAIT_STATES`, 1: extra cycles before the response, range 0..15.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_addr_i`  in  32  byte address; bits [1:0] ignored.
- `wb_sel_i`  in  4  byte lane enables; bit n covers data[8n+7:8n].
- `wb_data_i`  in  32  write data.
- `wb_data_o`  out  32  read data; valid only while `wb_ack_o` is 1, otherwise 0.
- `wb_ack_o`  out  1  normal termination, one-cycle pulse.
- `wb_err_o`  out  1  error termination, one-cycle pulse.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on `wb_cyc_i & wb_stb_i`, latch addr/we/sel/data and a hit flag. Hit means wb_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
  - WAIT_STATES == 0: go to RESP directly, performing the access at the same edge.
  - Otherwise: go to WAIT with wait counter = WAIT_STATES-1.
- WAIT:
  - `wb_cyc_i` == 0: abort. Return to IDLE; no write, no response.
  - Counter == 0: perform the access and go to RESP.
  - Otherwise: decrement the counter.
- Access on a hit:
  - Write: update only the bytes whose sel bit is 1. sel = 0 leaves memory unchanged but is still acknowledged.
  - Read: mem[idx] is registered into `wb_data_o`, where idx = latched addr[ADDR_WIDTH+1:2].
  - Response is `wb_ack_o` = 1.
- Access on a miss: no memory access; `wb_err_o` = 1 and `wb_data_o` = 0.
- RESP: the response outputs are high for this cycle only. The next edge unconditionally returns to IDLE and clears `wb_ack_o`, `wb_err_o` and `wb_data_o`. A strobe still high during RESP is not accepted.
- `wb_ack_o` and `wb_err_o` are never high together.
- The write-data path ignores `wb_data_i` after the latch; the latched copy is used.
- Memory contents are not reset (undefined after power-up); reset does not alter contents.

## Timing
- Reset (async, `rst` = 0): state IDLE, counter 0, and outputs `wb_ack_o` = 0, `wb_err_o` = 0, `wb_data_o` = 0. Any pending access is discarded with no write.
- Latency: strobe first sampled high at edge E0; response is high in the cycle after edge E0+WAIT_STATES. With WAIT_STATES = 0, the response appears one cycle after the strobe.
- Throughput: one transfer per WAIT_STATES+2 cycles. IDLE must see the strobe again after RESP.
- Handshake compatibility: the initiator drops stb/cyc at the edge where it samples ack. The RESP→IDLE transition at that same edge guarantees one ack per request.
- Abort is sampled only in WAIT. A cycle dropped in the acceptance cycle with WAIT_STATES = 0 has already committed the write.
- Read data comes from the array at the access edge. A write in the preceding transfer is visible: no bypass is needed, since transfers never overlap.

## Test plan
- Reset with `rst` = 0 mid-WAIT (write pending) → outputs 0 immediately. A later read of that address returns its prior value.
- WAIT_STATES = 1, write 32'hDEADBEEF to BASE+0x10 with sel = 4'hF, then read it → ack two cycles after each strobe; read data = 32'hDEADBEEF with ack; ack high for exactly 1 cycle.
- Byte masking: write 32'h11223344 (sel F), then 32'hAABBCCDD with sel = 4'b0101, then read → 32'h11BB33DD. A sel = 0 write is acked and leaves the value unchanged.
- Address BASE + 4·2^ADDR_WIDTH (out of window), read and write → `wb_err_o` pulse only, `wb_ack_o` = 0, `wb_data_o` = 0, memory unchanged.
- WAIT_STATES = 3, write with `wb_cyc_i` dropped after 1 wait cycle → no ack/err; a following read shows the old data; a new request is accepted on the next strobe.
- WAIT_STATES = 0, back-to-back requests with stb held continuously high → ack on alternate cycles, one ack per request, last address read back correctly.

Source files
------------

// File: rtl/wb_slave_ram.sv
// Wishbone classic-cycle slave in front of a word-organised RAM: one address window,
// fixed wait states, byte-masked writes, registered reads, single-cycle ack/err pulse.
module wb_slave_ram #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_addr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [1:0]  dbg_state_o
);

  // Bus handshake: a request is wb_cyc_i & wb_stb_i sampled in IDLE; it is answered by
  // exactly one cycle of wb_ack_o (hit) or wb_err_o (miss), unless wb_cyc_i drops in WAIT.

  localparam int         RegWidth = 32;
  localparam int         Depth    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CntInit  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  we_q;
  logic                  hit_q;
  logic [3:0]            sel_q;
  logic [RegWidth-1:0]   wdata_q;
  logic                  ack_q;
  logic                  err_q;
  logic [RegWidth-1:0]   rdata_q;

  logic [RegWidth-1:0]   mem [Depth];

  logic                  req;
  logic                  in_hit;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  acc_en;
  logic                  acc_hit;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [3:0]            acc_sel;
  logic [RegWidth-1:0]   acc_wdata;
  logic                  mem_we;
  logic [RegWidth-1:0]   rd_word;
  logic                  unused_addr_bits;

  assign req              = wb_cyc_i & wb_stb_i;
  assign in_hit           = (wb_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign in_idx           = wb_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^wb_addr_i[1:0];

  // With zero wait states the access uses the live bus inputs at the acceptance edge;
  // otherwise it uses the copy latched in IDLE.
  always_comb begin
    acc_en    = 1'b0;
    acc_hit   = hit_q;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_sel   = sel_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE && req && WAIT_STATES == 0) begin
      acc_en    = 1'b1;
      acc_hit   = in_hit;
      acc_we    = wb_we_i;
      acc_idx   = in_idx;
      acc_sel   = wb_sel_i;
      acc_wdata = wb_data_i;
    end else if (state_q == ST_WAIT && wb_cyc_i && cnt_q == 4'd0) begin
      acc_en = 1'b1;
    end
  end

  // rst gates the write so an edge during reset can never commit a pending access.
  assign mem_we  = acc_en & acc_hit & acc_we & rst;
  assign rd_word = mem[acc_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      sel_q   <= 4'd0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      if (acc_en) begin
        ack_q <= acc_hit;
        err_q <= ~acc_hit;
        if (acc_hit && !acc_we) rdata_q <= rd_word;
      end
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            idx_q   <= in_idx;
            we_q    <= wb_we_i;
            hit_q   <= in_hit;
            sel_q   <= wb_sel_i;
            wdata_q <= wb_data_i;
            cnt_q   <= CntInit;
            if (WAIT_STATES == 0) state_q <= ST_RESP;
            else                  state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i)           state_q <= ST_IDLE;
          else if (cnt_q == 4'd0) state_q <= ST_RESP;
          else                     cnt_q   <= cnt_q - 4'd1;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_data_o   = rdata_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: three instances with 1, 3 and 0 wait states share
// one clock and reset; every check is an immediate assertion against a hand-derived value.
module tb_wb_slave_ram;

  localparam logic [31:0] BASE1 = 32'h0002_0000;

  logic        clk;
  logic        rst_n;
  logic        cyc    [3];
  logic        stb    [3];
  logic        we_s   [3];
  logic [31:0] addr_s [3];
  logic [3:0]  sel_s  [3];
  logic [31:0] wdat   [3];
  logic [31:0] rdat   [3];
  logic        ack    [3];
  logic        err    [3];
  logic [1:0]  st     [3];

  int ws_tab [3] = '{1, 3, 0};
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] b2b_d [4] = '{32'h0101_0101, 32'h2222_0202, 32'h3303_3003, 32'h4444_4044};

  wb_slave_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we_s[0]),
    .wb_addr_i(addr_s[0]), .wb_sel_i(sel_s[0]), .wb_data_i(wdat[0]), .wb_data_o(rdat[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]), .dbg_state_o(st[0]));

  wb_slave_ram #(.ADDR_WIDTH(10), .BASE_ADDR(BASE1), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we_s[1]),
    .wb_addr_i(addr_s[1]), .wb_sel_i(sel_s[1]), .wb_data_i(wdat[1]), .wb_data_o(rdat[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]), .dbg_state_o(st[1]));

  wb_slave_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u2 (
    .clk(clk), .rst(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we_s[2]),
    .wb_addr_i(addr_s[2]), .wb_sel_i(sel_s[2]), .wb_data_i(wdat[2]), .wb_data_o(rdat[2]),
    .wb_ack_o(ack[2]), .wb_err_o(err[2]), .dbg_state_o(st[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus(input int i);
    cyc[i] = 1'b0; stb[i] = 1'b0; we_s[i] = 1'b0;
    addr_s[i] = 32'h0; sel_s[i] = 4'h0; wdat[i] = 32'h0;
  endtask

  // One full transfer; the bus copy of addr/data is scrambled after acceptance so
  // only the latched values can produce the expected result.
  task automatic xfer(input int i, input logic we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] data,
                      input logic exp_ack, input logic [31:0] exp_rdata, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we_s[i] = we;
    addr_s[i] = addr; sel_s[i] = sel; wdat[i] = data;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        wdat[i]   = ~data;
        addr_s[i] = addr ^ 32'h0000_0FF0;
      end
    end while (!(ack[i] || err[i]) && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'(ws_tab[i] + 1));
    check({tag, "_ack"}, {31'd0, ack[i]}, {31'd0, exp_ack});
    check({tag, "_err"}, {31'd0, err[i]}, {31'd0, ~exp_ack});
    if (!we || !exp_ack) check({tag, "_data"}, rdat[i], exp_ack ? exp_rdata : 32'h0);
    idle_bus(i);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, ack[i], err[i]}, 32'h0);
    check({tag, "_dclr"}, rdat[i], 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) idle_bus(i);

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out%0d", i), {rdat[i][29:0], ack[i], err[i]}, 32'h0);
      check($sformatf("rst_st%0d", i), {30'd0, st[i]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // reset while a write is pending in WAIT discards the write
    xfer(1, 1'b1, BASE1 + 32'h20, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0, "rst_pre_wr");
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b1;
    addr_s[1] = BASE1 + 32'h20; sel_s[1] = 4'hF; wdat[1] = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_in_wait", {30'd0, st[1]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_st", {30'd0, st[1]}, 32'h0);
    check("rst_mid_out", {rdat[1][29:0], ack[1], err[1]}, 32'h0);
    idle_bus(1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, BASE1 + 32'h20, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, "rst_rd_old");

    // basic write/read with one wait state
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0, "ws1_wr");
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, "ws1_rd");

    // byte masking
    xfer(0, 1'b1, 32'h40, 4'hF, 32'h1122_3344, 1'b1, 32'h0, "bm_wr_full");
    xfer(0, 1'b1, 32'h40, 4'b0101, 32'hAABB_CCDD, 1'b1, 32'h0, "bm_wr_0101");
    xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 32'h11BB_33DD, "bm_rd");
    xfer(0, 1'b1, 32'h40, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, "bm_wr_sel0");
    xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 32'h11BB_33DD, "bm_rd_sel0");

    // out of window: 0x1000 aliases index 0 but must not touch it
    xfer(0, 1'b1, 32'h0, 4'hF, 32'h0BAD_C0DE, 1'b1, 32'h0, "oow_seed");
    xfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, 32'h0, "oow_rd");
    xfer(0, 1'b1, 32'h1000, 4'hF, 32'h5555_5555, 1'b0, 32'h0, "oow_wr");
    xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'h0BAD_C0DE, "oow_rd_back");
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h0, "oow_base1");

    // abort after one wait cycle with three wait states
    xfer(1, 1'b1, BASE1 + 32'h30, 4'hF, 32'hA5A5_A5A5, 1'b1, 32'h0, "abt_seed");
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b1;
    addr_s[1] = BASE1 + 32'h30; sel_s[1] = 4'hF; wdat[1] = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_bus(1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abt_quiet%0d", k), {30'd0, ack[1], err[1]}, 32'h0);
    end
    check("abt_idle", {30'd0, st[1]}, 32'h0);
    xfer(1, 1'b0, BASE1 + 32'h30, 4'hF, 32'h0, 1'b1, 32'hA5A5_A5A5, "abt_rd_old");

    // zero wait states, strobe held high across back-to-back requests
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we_s[2] = 1'b1;
    addr_s[2] = 32'h0; sel_s[2] = 4'hF; wdat[2] = b2b_d[0];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ack%0d", k), {30'd0, ack[2], err[2]}, 32'h2);
      if (k == 4) check("b2b_rd_last", rdat[2], b2b_d[3]);
      if (k < 3) begin
        addr_s[2] = 32'(4 * (k + 1)); wdat[2] = b2b_d[k+1];
      end else if (k == 3) begin
        we_s[2] = 1'b0; addr_s[2] = 32'hC; wdat[2] = 32'h0;
      end else begin
        idle_bus(2);
      end
      @(posedge clk); #1;
      check($sformatf("b2b_gap%0d", k), {30'd0, ack[2], err[2]}, 32'h0);
    end
    xfer(2, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1, b2b_d[1], "b2b_rd1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
